// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO family.
// Read-mode selectors and the pointer-width helper.
// No logic; imported by the FIFO top.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointers carry one extra wrap bit beyond the memory index
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH storage, one synchronous write port, one async read port.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the caller only writes accepted words.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_BITS  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost flags, sticky errors, high-water stat.
// Latency: 1 cycle read in standard mode; head word visible 1 cycle after write in FWFT mode.
// Backpressure: writes to a full FIFO are dropped (overflow) unless a read frees a slot.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_BITS  = $clog2(DEPTH),
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_BITS:0]    af_thresh,
    input  logic [ADDR_BITS:0]    ae_thresh,
    input  logic                  stat_clr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ovf_sticky,
    output logic                  unf_sticky,
    output logic [ADDR_BITS:0]    count,
    output logic [ADDR_BITS:0]    high_water
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      count_next;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  wr_rej;
    logic                  rd_rej;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Occupancy is the pointer distance; the wrap bit disambiguates full from empty
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    // A read frees a slot in the same cycle, so a full FIFO can still take a write
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);
    assign wr_rej = wr_en && !wr_acc;
    assign rd_rej = rd_en && !rd_acc;

    // Occupancy after this edge, feeding the high-water statistic
    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + PTR_W'(1);
            2'b01:   count_next = count - PTR_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointer advance on accepted transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Error pulses, sticky copies (set beats clear) and high-water tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
            high_water <= '0;
        end else begin
            overflow  <= wr_rej;
            underflow <= rd_rej;
            if (wr_rej) begin
                ovf_sticky <= 1'b1;
            end else if (stat_clr) begin
                ovf_sticky <= 1'b0;
            end
            if (rd_rej) begin
                unf_sticky <= 1'b1;
            end else if (stat_clr) begin
                unf_sticky <= 1'b0;
            end
            if (stat_clr || (count_next > high_water)) begin
                high_water <= count_next;
            end
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_BITS-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ADDR_BITS-1:0]),
        .rd_data (mem_rd_data)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented directly; zero when nothing is queued
        assign rd_data = empty ? '0 : mem_rd_data;
    end else begin : g_std
        // Registered read port, updated only on accepted reads
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data <= '0;
            end else if (rd_acc) begin
                rd_data <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: standard and FWFT builds driven side by side.
// Queue-based reference model checked on every falling edge, plus literal pins.
// Directed test-plan scenarios followed by a biased random phase.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [4:0] af_thresh;
    logic [4:0] ae_thresh;
    logic       stat_clr;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_ovs, s_uns;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_ovs, f_uns;
    logic [4:0] s_count, s_hw, f_count, f_hw;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf = 0, m_unf = 0, m_ovs = 0, m_uns = 0;
    int         m_hw = 0;
    logic [7:0] m_rd = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .stat_clr(stat_clr), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf),
        .ovf_sticky(s_ovs), .unf_sticky(s_uns), .count(s_count), .high_water(s_hw)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .stat_clr(stat_clr), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf),
        .ovf_sticky(f_ovs), .unf_sticky(f_uns), .count(f_count), .high_water(f_hw)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of words plus counters, advanced per clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_ovs = 0; m_uns = 0; m_hw = 0; m_rd = 8'h00;
        end else begin
            bit racc, wacc;
            racc = rd_en && (mq.size() != 0);
            wacc = wr_en && ((mq.size() != 16) || racc);
            if (racc) m_rd = mq.pop_front();
            if (wacc) mq.push_back(wr_data);
            m_ovf = wr_en && !wacc;
            m_unf = rd_en && !racc;
            if (m_ovf) m_ovs = 1; else if (stat_clr) m_ovs = 0;
            if (m_unf) m_uns = 1; else if (stat_clr) m_uns = 0;
            if (stat_clr || mq.size() > m_hw) m_hw = mq.size();
        end
    end

    // Every-cycle comparison of both builds against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            logic [7:0] head;
            n = mq.size();
            head = (n != 0) ? mq[0] : 8'h00;
            chk("s_count", 32'(s_count), 32'(n));
            chk("f_count", 32'(f_count), 32'(n));
            chk("s_full",  32'(s_full),  32'(n == 16));
            chk("f_full",  32'(f_full),  32'(n == 16));
            chk("s_empty", 32'(s_empty), 32'(n == 0));
            chk("f_empty", 32'(f_empty), 32'(n == 0));
            chk("s_af",    32'(s_af),    32'(n >= int'(af_thresh)));
            chk("f_af",    32'(f_af),    32'(n >= int'(af_thresh)));
            chk("s_ae",    32'(s_ae),    32'(n <= int'(ae_thresh)));
            chk("f_ae",    32'(f_ae),    32'(n <= int'(ae_thresh)));
            chk("s_ovf",   32'(s_ovf),   32'(m_ovf));
            chk("f_ovf",   32'(f_ovf),   32'(m_ovf));
            chk("s_unf",   32'(s_unf),   32'(m_unf));
            chk("f_unf",   32'(f_unf),   32'(m_unf));
            chk("s_ovs",   32'(s_ovs),   32'(m_ovs));
            chk("f_ovs",   32'(f_ovs),   32'(m_ovs));
            chk("s_uns",   32'(s_uns),   32'(m_uns));
            chk("f_uns",   32'(f_uns),   32'(m_uns));
            chk("s_hw",    32'(s_hw),    32'(m_hw));
            chk("f_hw",    32'(f_hw),    32'(m_hw));
            chk("s_rd_data", 32'(s_rd_data), 32'(m_rd));
            chk("f_rd_data", 32'(f_rd_data), 32'(head));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic w, input logic [7:0] d, input logic r);
        wr_en = w; wr_data = d; rd_en = r;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
        af_thresh = 5'd14; ae_thresh = 5'd2; stat_clr = 1'b0;
        #1;
        // Reset values
        chk("rst_count", 32'(s_count), 0);
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_full",  32'(s_full),  0);
        chk("rst_ae",    32'(s_ae),    1);
        chk("rst_af",    32'(s_af),    0);
        chk("rst_hw",    32'(s_hw),    0);
        #11;
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // 1: fill 16, drain 16 in order
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 8'(i), 1'b0);
            chk("fill_af", 32'(s_af), 32'(i + 1 >= 14));
        end
        chk("fill_count", 32'(s_count), 16);
        chk("fill_full",  32'(s_full),  1);
        chk("fill_hw",    32'(s_hw),    16);
        for (int i = 0; i < 16; i++) begin
            chk("fwft_head", 32'(f_rd_data), 32'(i));
            op(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(s_rd_data), 32'(i));
        end
        chk("drain_empty", 32'(s_empty), 1);
        chk("drain_count", 32'(s_count), 0);

        // 2: overflow when full, write+read when full
        for (int i = 0; i < 16; i++) op(1'b1, 8'(8'h20 + i), 1'b0);
        op(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse",  32'(s_ovf),   1);
        chk("ovf_sticky", 32'(s_ovs),   1);
        chk("ovf_count",  32'(s_count), 16);
        tick();
        chk("ovf_one_cycle", 32'(s_ovf), 0);
        op(1'b1, 8'hBB, 1'b1);
        chk("wr_rd_full_ovf",   32'(s_ovf),     0);
        chk("wr_rd_full_count", 32'(s_count),   16);
        chk("wr_rd_full_data",  32'(s_rd_data), 32'h20);
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 8'h00, 1'b1);
            chk("ovf_drain", 32'(s_rd_data), (i < 15) ? 32'(8'h21 + i) : 32'hBB);
        end

        // 3: underflow on empty, write+read on empty
        op(1'b0, 8'h00, 1'b1);
        chk("unf_pulse",  32'(s_unf),     1);
        chk("unf_sticky", 32'(s_uns),     1);
        chk("unf_hold",   32'(s_rd_data), 32'hBB);
        op(1'b1, 8'h55, 1'b1);
        chk("unf_wr_pulse", 32'(s_unf),   1);
        chk("unf_wr_count", 32'(s_count), 1);
        op(1'b0, 8'h00, 1'b1);
        chk("unf_wr_data",  32'(s_rd_data), 32'h55);
        chk("unf_clear",    32'(s_unf),     0);

        // 4: FWFT visibility and pop
        op(1'b1, 8'h3C, 1'b0);
        chk("fwft_vis",   32'(f_rd_data), 32'h3C);
        op(1'b0, 8'h00, 1'b1);
        chk("fwft_empty", 32'(f_empty),   1);
        chk("fwft_zero",  32'(f_rd_data), 0);
        chk("std_3c",     32'(s_rd_data), 32'h3C);

        // 5: threshold change and statistics clear
        for (int i = 0; i < 5; i++) op(1'b1, 8'(8'h40 + i), 1'b0);
        chk("af_before", 32'(s_af), 0);
        af_thresh = 5'd5;
        #1;
        chk("af_same_cycle", 32'(s_af), 1);
        chk("hw_before_clr", 32'(s_hw), 16);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("hw_clr",  32'(s_hw),  5);
        chk("ovs_clr", 32'(s_ovs), 0);
        chk("uns_clr", 32'(s_uns), 0);
        af_thresh = 5'd14;

        // 6: asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) op(1'b0, 8'h00, 1'b1);
        op(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) op(1'b1, 8'(8'h60 + i), 1'b0);
        chk("pre_rst_count", 32'(s_count), 10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(s_empty),   1);
        chk("arst_count", 32'(s_count),   0);
        chk("arst_uns",   32'(s_uns),     0);
        chk("arst_hw",    32'(s_hw),      0);
        chk("arst_rd",    32'(s_rd_data), 0);
        chk("arst_frd",   32'(f_rd_data), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        op(1'b1, 8'h77, 1'b0);
        chk("post_rst_fwft", 32'(f_rd_data), 32'h77);
        op(1'b0, 8'h00, 1'b1);
        chk("post_rst_std", 32'(s_rd_data), 32'h77);

        // Random phase: alternating fill-heavy, drain-heavy and balanced traffic
        for (int c = 0; c < 3000; c++) begin
            int bias;
            bias = (c / 250) % 3;
            wr_en    = $urandom_range(0, 99) < ((bias == 0) ? 80 : (bias == 1) ? 20 : 50);
            rd_en    = $urandom_range(0, 99) < ((bias == 0) ? 20 : (bias == 1) ? 80 : 50);
            wr_data  = 8'($urandom);
            stat_clr = ($urandom_range(0, 99) < 3);
            if (c % 400 == 0) begin
                af_thresh = 5'($urandom_range(0, 16));
                ae_thresh = 5'($urandom_range(0, 16));
            end
            tick();
            if (c == 1777) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk("rnd_arst_count", 32'(s_count), 0);
                rst_n = 1'b1;
            end
        end
        wr_en = 1'b0; rd_en = 1'b0; stat_clr = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
